// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared types and encodings for the multicycle controller
// Purpose: FSM state enum, RV32I opcode constants, datapath select encodings,
//          branch funct3 constants and an opcode-legality helper.
// Ports:   none (package).
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_JALWB    = 4'd12,
        S_LUI      = 4'd13,
        S_HALT     = 4'd14
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;
    localparam logic [1:0] RES_IMM       = 2'b11;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    function automatic logic is_known_op(input logic [6:0] o);
        case (o)
            OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH,
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: return 1'b1;
            default:                           return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// rtl/multicycle_controller_if.sv - unified memory port handshake bundle
// Purpose: request/ready handshake plus store strobe and address select.
// Ports:   mem_req, MemWrite, AdrSrc (controller -> memory), mem_ready (memory -> controller).
interface multicycle_controller_if;
    logic mem_req;
    logic mem_ready;
    logic MemWrite;
    logic AdrSrc;

    modport master (output mem_req, output MemWrite, output AdrSrc, input mem_ready);
    modport slave  (input mem_req, input MemWrite, input AdrSrc, output mem_ready);
endinterface

// File: rtl/multicycle_controller_branch_cond.sv
// rtl/multicycle_controller_branch_cond.sv - branch taken resolution from ALU flags
// Purpose: combinational funct3/zero/lt/ltu -> taken.
// Ports:   funct3, zero, lt, ltu in; taken out.
module branch_cond
    import mc_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       lt,
    input  logic       ltu,
    output logic       taken
);
    always_comb begin
        taken = 1'b0;
        case (funct3)
            F3_BEQ:  taken = zero;
            F3_BNE:  taken = !zero;
            F3_BLT:  taken = lt;
            F3_BGE:  taken = !lt;
            F3_BLTU: taken = ltu;
            F3_BGEU: taken = !ltu;
            default: taken = 1'b0;
        endcase
    end
endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - Moore FSM sequencing the RV32I multicycle datapath
// Purpose: per-state mux selects and write strobes, memory wait/timeout, branch resolution.
// Ports:   clk, rst_n (sync active-low); mem (memory handshake, master);
//          op/funct3/funct7b5/zero/lt/ltu in; IRWrite, PCWrite, RegWrite, ResultSrc,
//          ALUSrcA, ALUSrcB, ALUOp, ImmSrc, instr_done, bus_err, halted out.
// Option:  ILLEGAL_TRAP_EN - unknown opcodes halt and raise illegal_op (port only then).
module multicycle_controller
    import mc_pkg::*;
#(
    parameter int WAIT_W   = 4,
    parameter int MAX_WAIT = 15
) (
    input  logic                            clk,
    input  logic                            rst_n,
    multicycle_controller_if.master         mem,
    input  logic [6:0]                      op,
    input  logic [2:0]                      funct3,
    input  logic                            funct7b5,
    input  logic                            zero,
    input  logic                            lt,
    input  logic                            ltu,
    output logic                            IRWrite,
    output logic                            PCWrite,
    output logic                            RegWrite,
    output logic [1:0]                      ResultSrc,
    output logic [1:0]                      ALUSrcA,
    output logic [1:0]                      ALUSrcB,
    output logic [1:0]                      ALUOp,
    output logic [2:0]                      ImmSrc,
    output logic                            instr_done,
    output logic                            bus_err,
    output logic                            halted
`ifdef ILLEGAL_TRAP_EN
    ,
    output logic                            illegal_op
`endif
);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

    state_t            state, next_state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              taken, timeout;
    logic              req_raw, mw_raw, irw_raw, pcw_raw, rw_raw, done_raw, adr_src;

    // funct7b5 only matters to the downstream ALU decoder
    logic unused_funct7b5;
    assign unused_funct7b5 = funct7b5;

    branch_cond u_branch_cond (
        .funct3 (funct3),
        .zero   (zero),
        .lt     (lt),
        .ltu    (ltu),
        .taken  (taken)
    );

    // mem_ready on the limit cycle still completes the access
    assign timeout = req_raw && !mem.mem_ready && (wait_cnt == WAIT_LIMIT);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_FETCH;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_FETCH:    if (timeout) next_state = S_HALT;
                        else if (mem.mem_ready) next_state = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: next_state = S_MEMADR;
                    OP_RTYPE:          next_state = S_EXECR;
                    OP_ITYPE:          next_state = S_EXECI;
                    OP_BRANCH:         next_state = S_BRANCH;
                    OP_JAL:            next_state = S_JAL;
                    OP_JALR:           next_state = S_JALR;
                    OP_LUI:            next_state = S_LUI;
                    OP_AUIPC:          next_state = S_ALUWB;
`ifdef ILLEGAL_TRAP_EN
                    default:           next_state = S_HALT;
`else
                    default:           next_state = S_FETCH;
`endif
                endcase
            end
            S_MEMADR:   next_state = op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (timeout) next_state = S_HALT;
                        else if (mem.mem_ready) next_state = S_MEMWB;
            S_MEMWRITE: if (timeout) next_state = S_HALT;
                        else if (mem.mem_ready) next_state = S_FETCH;
            S_EXECR, S_EXECI, S_JAL: next_state = S_ALUWB;
            S_JALR:     next_state = S_JALWB;
            S_MEMWB, S_ALUWB, S_BRANCH, S_JALWB, S_LUI: next_state = S_FETCH;
            S_HALT:     next_state = S_HALT;
            default:    next_state = S_FETCH;
        endcase
    end

    always_comb begin
        req_raw   = 1'b0;
        mw_raw    = 1'b0;
        adr_src   = 1'b0;
        irw_raw   = 1'b0;
        pcw_raw   = 1'b0;
        rw_raw    = 1'b0;
        done_raw  = 1'b0;
        ResultSrc = RES_ALUOUT;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_RS2;
        ALUOp     = ALUOP_ADD;
        case (state)
            S_FETCH: begin
                req_raw   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                irw_raw   = mem.mem_ready;
                pcw_raw   = mem.mem_ready;
            end
            S_DECODE: begin
                ALUSrcA  = SRCA_OLDPC;
                ALUSrcB  = SRCB_IMM;
`ifndef ILLEGAL_TRAP_EN
                done_raw = !is_known_op(op);
`endif
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMREAD: begin
                req_raw = 1'b1;
                adr_src = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                rw_raw    = 1'b1;
                done_raw  = 1'b1;
            end
            S_MEMWRITE: begin
                req_raw  = 1'b1;
                mw_raw   = 1'b1;
                adr_src  = 1'b1;
                done_raw = mem.mem_ready;
            end
            S_EXECR: begin
                ALUSrcA = SRCA_RS1;
                ALUOp   = ALUOP_FUNCT;
            end
            S_EXECI: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                ALUOp   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                rw_raw   = 1'b1;
                done_raw = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA  = SRCA_RS1;
                ALUOp    = ALUOP_SUB;
                pcw_raw  = taken;
                done_raw = 1'b1;
            end
            S_JAL: begin
                pcw_raw = 1'b1;
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_FOUR;
            end
            S_JALR: begin
                ALUSrcA   = SRCA_RS1;
                ALUSrcB   = SRCB_IMM;
                ResultSrc = RES_ALURESULT;
                pcw_raw   = 1'b1;
            end
            S_JALWB: begin
                ALUSrcA   = SRCA_OLDPC;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                rw_raw    = 1'b1;
                done_raw  = 1'b1;
            end
            S_LUI: begin
                ResultSrc = RES_IMM;
                rw_raw    = 1'b1;
                done_raw  = 1'b1;
            end
            default: ;
        endcase
    end

    // strobes are gated by rst_n so an access in flight is dropped in the reset cycle
    assign mem.mem_req  = req_raw  & rst_n;
    assign mem.MemWrite = mw_raw   & rst_n;
    assign mem.AdrSrc   = adr_src;
    assign IRWrite      = irw_raw  & rst_n;
    assign PCWrite      = pcw_raw  & rst_n;
    assign RegWrite     = rw_raw   & rst_n;
    assign instr_done   = done_raw & rst_n;
    assign halted       = (state == S_HALT);

    always_comb begin
        ImmSrc = IMM_I;
        case (op)
            OP_STORE:         ImmSrc = IMM_S;
            OP_BRANCH:        ImmSrc = IMM_B;
            OP_JAL:           ImmSrc = IMM_J;
            OP_LUI, OP_AUIPC: ImmSrc = IMM_U;
            default:          ImmSrc = IMM_I;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n)                 wait_cnt <= '0;
        else if (next_state != state) wait_cnt <= '0;
        else if (req_raw && !mem.mem_ready) wait_cnt <= wait_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)       bus_err <= 1'b0;
        else if (timeout) bus_err <= 1'b1;
    end

`ifdef ILLEGAL_TRAP_EN
    always_ff @(posedge clk) begin
        if (!rst_n)                                      illegal_op <= 1'b0;
        else if (state == S_DECODE && !is_known_op(op)) illegal_op <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - directed self-checking bench for multicycle_controller
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero, lt, ltu;
    logic       IRWrite, PCWrite, RegWrite, instr_done, bus_err, halted;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
    logic [2:0] ImmSrc;
`ifdef ILLEGAL_TRAP_EN
    logic       illegal_op;
`endif

    int n_cmp = 0;
    int n_err = 0;

    multicycle_controller_if mif ();

    multicycle_controller dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem        (mif),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .zero       (zero),
        .lt         (lt),
        .ltu        (ltu),
        .IRWrite    (IRWrite),
        .PCWrite    (PCWrite),
        .RegWrite   (RegWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUOp      (ALUOp),
        .ImmSrc     (ImmSrc),
        .instr_done (instr_done),
        .bus_err    (bus_err),
        .halted     (halted)
`ifdef ILLEGAL_TRAP_EN
        ,
        .illegal_op (illegal_op)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        mif.mem_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // one-cycle fetch; leaves the FSM at the start of S_DECODE
    task automatic do_fetch(input logic [6:0] o, input logic [2:0] f3);
        op = o;
        funct3 = f3;
        mif.mem_ready = 1'b1;
        settle();
        check_val("fetch_irwrite", IRWrite, 1);
        check_val("fetch_pcwrite", PCWrite, 1);
        tick();
        mif.mem_ready = 1'b0;
    endtask

    task automatic do_branch(input string tag, input logic [2:0] f3, input logic z,
                             input logic l, input logic lu, input logic exp_taken);
        do_fetch(7'b1100011, f3);
        zero = z;
        lt = l;
        ltu = lu;
        settle();
        check_val("decode_immsrc_b", ImmSrc, 3'b010);
        tick();
        settle();
        check_val(tag, PCWrite, exp_taken);
        check_val("branch_done", instr_done, 1);
        check_val("branch_aluop", ALUOp, 2'b01);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n_rw, rw_at, n_done, done_at;

        rst_n = 1'b0;
        mif.mem_ready = 1'b1;
        op = 7'b0000011;
        funct3 = 3'b000;
        funct7b5 = 1'b0;
        zero = 1'b0;
        lt = 1'b0;
        ltu = 1'b0;
        tick();
        tick();
        settle();
        check_val("rst_mem_req", mif.mem_req, 0);
        check_val("rst_irwrite", IRWrite, 0);
        check_val("rst_pcwrite", PCWrite, 0);

        rst_n = 1'b1;
        mif.mem_ready = 1'b0;
        settle();
        check_val("fetch_req", mif.mem_req, 1);
        check_val("fetch_adrsrc", mif.AdrSrc, 0);
        check_val("fetch_srcb", ALUSrcB, 2'b10);
        check_val("fetch_result", ResultSrc, 2'b10);
        check_val("rst_halted", halted, 0);
        check_val("rst_bus_err", bus_err, 0);

        // lw: ready on fetch cycle 2 and read cycle 3 -> writeback on cycle 9
        n_rw = 0; rw_at = -1; n_done = 0; done_at = -1;
        for (int i = 0; i < 10; i++) begin
            mif.mem_ready = (i == 2) || (i == 8);
            settle();
            if (RegWrite) begin n_rw++; rw_at = i; end
            if (instr_done) begin n_done++; done_at = i; end
            if (i == 3) begin
                check_val("lw_decode_srca", ALUSrcA, 2'b01);
                check_val("lw_immsrc", ImmSrc, 3'b000);
            end
            if (i == 5) begin
                check_val("lw_read_adrsrc", mif.AdrSrc, 1);
                check_val("lw_read_req", mif.mem_req, 1);
            end
            if (i == 9) check_val("lw_wb_result", ResultSrc, 2'b01);
            tick();
        end
        mif.mem_ready = 1'b0;
        check_val("lw_regwrite_count", n_rw, 1);
        check_val("lw_regwrite_cycle", rw_at, 9);
        check_val("lw_done_count", n_done, 1);
        check_val("lw_done_cycle", done_at, 9);

        // sw
        do_fetch(7'b0100011, 3'b010);
        settle();
        check_val("sw_immsrc", ImmSrc, 3'b001);
        tick();
        settle();
        check_val("sw_adr_srca", ALUSrcA, 2'b10);
        check_val("sw_adr_srcb", ALUSrcB, 2'b01);
        tick();
        mif.mem_ready = 1'b1;
        settle();
        check_val("sw_memwrite", mif.MemWrite, 1);
        check_val("sw_adrsrc", mif.AdrSrc, 1);
        check_val("sw_done", instr_done, 1);
        tick();
        mif.mem_ready = 1'b0;

        do_branch("beq_z1_taken",    3'b000, 1, 0, 0, 1);
        do_branch("bgeu_ltu1_not",   3'b111, 0, 0, 1, 0);
        do_branch("f3_010_never",    3'b010, 1, 1, 1, 0);
        do_branch("bne_z1_not",      3'b001, 1, 0, 0, 0);
        do_branch("blt_lt1_taken",   3'b100, 0, 1, 0, 1);
        do_branch("bgeu_ltu0_taken", 3'b111, 0, 0, 0, 1);

        // jalr
        do_fetch(7'b1100111, 3'b000);
        settle();
        tick();
        settle();
        check_val("jalr_pcwrite", PCWrite, 1);
        check_val("jalr_regwrite", RegWrite, 0);
        check_val("jalr_srca", ALUSrcA, 2'b10);
        tick();
        settle();
        check_val("jalwb_regwrite", RegWrite, 1);
        check_val("jalwb_result", ResultSrc, 2'b10);
        check_val("jalwb_srca", ALUSrcA, 2'b01);
        check_val("jalwb_srcb", ALUSrcB, 2'b10);
        check_val("jalwb_pcwrite", PCWrite, 0);
        check_val("jalwb_done", instr_done, 1);
        tick();

        // R-type
        do_fetch(7'b0110011, 3'b000);
        settle();
        tick();
        settle();
        check_val("execr_aluop", ALUOp, 2'b10);
        check_val("execr_srcb", ALUSrcB, 2'b00);
        tick();
        settle();
        check_val("aluwb_regwrite", RegWrite, 1);
        check_val("aluwb_result", ResultSrc, 2'b00);
        check_val("aluwb_done", instr_done, 1);
        tick();

        // unlisted opcode
        do_fetch(7'b0000000, 3'b000);
        settle();
`ifdef ILLEGAL_TRAP_EN
        check_val("illegal_decode_done", instr_done, 0);
        tick();
        settle();
        check_val("illegal_halted", halted, 1);
        check_val("illegal_flag", illegal_op, 1);
        do_reset();
`else
        check_val("nop_done", instr_done, 1);
        check_val("nop_regwrite", RegWrite, 0);
        check_val("nop_pcwrite", PCWrite, 0);
        tick();
        settle();
        check_val("nop_back_fetch", mif.mem_req, 1);
        check_val("nop_halted", halted, 0);
`endif

        // ready arrives on cycle 15 of fetch: no error
        op = 7'b0110111;
        for (int i = 0; i < 16; i++) begin
            mif.mem_ready = (i == 15);
            settle();
            if (i == 15) check_val("late_ready_irwrite", IRWrite, 1);
            tick();
        end
        mif.mem_ready = 1'b0;
        settle();
        check_val("late_ready_bus_err", bus_err, 0);
        check_val("late_ready_halted", halted, 0);
        tick();
        settle();
        check_val("lui_regwrite", RegWrite, 1);
        check_val("lui_result", ResultSrc, 2'b11);
        check_val("lui_done", instr_done, 1);
        tick();

        // ready never arrives: halt after 16 waiting cycles
        for (int i = 0; i < 16; i++) begin
            mif.mem_ready = 1'b0;
            settle();
            if (i == 15) check_val("timeout_not_yet", halted, 0);
            tick();
        end
        settle();
        check_val("timeout_halted", halted, 1);
        check_val("timeout_bus_err", bus_err, 1);
        check_val("timeout_mem_req", mif.mem_req, 0);
        mif.mem_ready = 1'b1;
        settle();
        check_val("halt_irwrite", IRWrite, 0);
        tick();
        settle();
        check_val("halt_sticky", halted, 1);

        // reset during a stalled store
        do_reset();
        settle();
        check_val("reset_clears_bus_err", bus_err, 0);
        do_fetch(7'b0100011, 3'b010);
        settle();
        tick();
        settle();
        tick();
        settle();
        check_val("stall_memwrite", mif.MemWrite, 1);
        rst_n = 1'b0;
        settle();
        check_val("rst_drops_memwrite", mif.MemWrite, 0);
        check_val("rst_drops_req", mif.mem_req, 0);
        tick();
        rst_n = 1'b1;
        settle();
        check_val("after_rst_req", mif.mem_req, 1);
        check_val("after_rst_adrsrc", mif.AdrSrc, 0);
        check_val("after_rst_srcb", ALUSrcB, 2'b10);
        check_val("after_rst_memwrite", mif.MemWrite, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
